// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the RV32C prefetch stage.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_t;

  localparam int HALF_BYTES = 2;
  localparam int WORD_BYTES = 4;

  function automatic logic [31:0] word_align(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_hword_fifo.sv
// Halfword instruction FIFO with dual push, single pop and synchronous flush.
module inst_fetch_hword_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push0,
  input  logic                     push1,
  input  logic                     pop,
  input  logic [31:0]              pc0,
  input  logic [15:0]              inst0,
  input  logic [31:0]              pc1,
  input  logic [15:0]              inst1,
  output logic [31:0]              head_pc,
  output logic [15:0]              head_inst,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr1;
  logic [31:0]   pc_mem   [DEPTH];
  logic [15:0]   inst_mem [DEPTH];
  logic          do_pop;

  assign empty     = (count == '0);
  assign do_pop    = pop & ~empty;
  // push1 lands behind push0 when both halves arrive together
  assign wr_ptr1   = push0 ? wr_ptr + AW'(1) : wr_ptr;
  assign head_pc   = pc_mem[rd_ptr];
  assign head_inst = inst_mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push0) begin
        pc_mem[wr_ptr]   <= pc0;
        inst_mem[wr_ptr] <= inst0;
      end
      if (push1) begin
        pc_mem[wr_ptr1]   <= pc1;
        inst_mem[wr_ptr1] <= inst1;
      end
      wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push0) + CW'(push1) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Prefetch stage: fetches 32-bit words, splits them into compressed halfwords
// and streams them to the core; a redirect flushes and restarts fetch.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no request outstanding; issue one when >= 2 slots are free
// REQ     | mem_req held with a stable address until mem_gnt
// WAIT    | granted, waiting for mem_rvalid (dropped if drop is set)
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [15:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic          drop;
  logic [CW-1:0] count;
  logic          empty;
  logic          slots_ok;
  logic          accept;
  logic          push0;
  logic          push1;
  logic [31:0]   word_pc;
  logic [31:0]   new_pc;

  assign word_pc    = word_align(fetch_pc);
  assign new_pc     = redirect_pc & ~32'h1;
  assign slots_ok   = (count <= CW'(DEPTH - 2));
  // a redirect or a pending drop kills the response in flight
  assign accept     = (state == ST_WAIT) & mem_rvalid & ~drop & ~redirect;
  assign push0      = accept & ~fetch_pc[1];
  assign push1      = accept;
  assign inst_valid = ~empty;

  inst_fetch_hword_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect),
    .push0     (push0),
    .push1     (push1),
    .pop       (inst_ready),
    .pc0       (word_pc),
    .inst0     (mem_rdata[15:0]),
    .pc1       (word_pc + 32'(HALF_BYTES)),
    .inst1     (mem_rdata[31:16]),
    .head_pc   (inst_pc),
    .head_inst (inst),
    .count     (count),
    .empty     (empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC & ~32'h1;
      drop     <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (redirect) begin
            fetch_pc <= new_pc;
            state    <= ST_REQ;
            mem_req  <= 1'b1;
            mem_addr <= word_align(new_pc);
          end else if (slots_ok) begin
            state    <= ST_REQ;
            mem_req  <= 1'b1;
            mem_addr <= word_pc;
          end
        end
        ST_REQ: begin
          // the address stays put until granted; the stale reply is dropped later
          if (redirect) begin
            fetch_pc <= new_pc;
            drop     <= 1'b1;
          end
          if (mem_gnt) begin
            state   <= ST_WAIT;
            mem_req <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            state <= ST_IDLE;
            drop  <= 1'b0;
            if (redirect)  fetch_pc <= new_pc;
            else if (!drop) fetch_pc <= word_pc + 32'(WORD_BYTES);
          end else if (redirect) begin
            fetch_pc <= new_pc;
            drop     <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: one task per scenario, hand-computed expectations.
module tb_inst_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        reset_w;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        mem_req,   w_mem_req;
  logic [31:0] mem_addr,  w_mem_addr;
  logic        inst_valid, w_inst_valid;
  logic [15:0] inst,      w_inst;
  logic [31:0] inst_pc,   w_inst_pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(4)) dut_w (
    .clock(clock), .reset(reset_w),
    .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .inst_valid(w_inst_valid), .inst(w_inst), .inst_pc(w_inst_pc),
    .inst_ready(inst_ready), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", mem_req); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
    n_checks++; if (inst !== 16'h0) begin n_fail++; $display("FAIL rst_inst: got %h want 0", inst); end
    n_checks++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", inst_pc); end
  endtask

  task automatic test_basic_fetch();
    apply_reset();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL t1_idle_req: got %b want 0", mem_req); end
    tick();
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL t1_req0: got req=%b addr=%h want 1/0", mem_req, mem_addr); end
    mem_gnt = 1'b1; tick();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL t1_req_drop: got %b want 0", mem_req); end
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0001_4081; tick();
    mem_rvalid = 1'b0;
    n_checks++; if (inst_valid !== 1'b1 || inst !== 16'h4081 || inst_pc !== 32'h0) begin n_fail++; $display("FAIL t1_first: got v=%b %h@%h want 1 4081@0", inst_valid, inst, inst_pc); end
    inst_ready = 1'b1; tick();
    n_checks++; if (inst_valid !== 1'b1 || inst !== 16'h0001 || inst_pc !== 32'h2) begin n_fail++; $display("FAIL t1_second: got v=%b %h@%h want 1 0001@2", inst_valid, inst, inst_pc); end
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin n_fail++; $display("FAIL t1_next_addr: got req=%b addr=%h want 1/4", mem_req, mem_addr); end
    tick();
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL t1_drained: got %b want 0", inst_valid); end
    inst_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_inst [4];
    exp_inst[0] = 16'h1111; exp_inst[1] = 16'h2222; exp_inst[2] = 16'h3333; exp_inst[3] = 16'h4444;
    apply_reset();
    tick();
    mem_gnt = 1'b1; tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h2222_1111; tick();
    mem_rvalid = 1'b0; tick();
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin n_fail++; $display("FAIL t2_req4: got req=%b addr=%h want 1/4", mem_req, mem_addr); end
    mem_gnt = 1'b1; tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h4444_3333; tick();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL t2_full_req[%0d]: got %b want 0", i, mem_req); end
      n_checks++; if (inst_valid !== 1'b1 || inst !== 16'h1111 || inst_pc !== 32'h0) begin n_fail++; $display("FAIL t2_head_hold[%0d]: got v=%b %h@%h want 1 1111@0", i, inst_valid, inst, inst_pc); end
      tick();
    end
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (inst_valid !== 1'b1 || inst !== exp_inst[i] || inst_pc !== 32'(2 * i)) begin n_fail++; $display("FAIL t2_pop[%0d]: got v=%b %h@%h want 1 %h@%h", i, inst_valid, inst, inst_pc, exp_inst[i], 2 * i); end
      tick();
    end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL t2_empty: got %b want 0", inst_valid); end
    inst_ready = 1'b0;
  endtask

  task automatic test_redirect_wait();
    apply_reset();
    tick();
    mem_gnt = 1'b1; tick();
    mem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0102; tick();
    redirect = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; tick();
    mem_rvalid = 1'b0;
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL t3_stale: got v=%b inst=%h want v=0", inst_valid, inst); end
    tick();
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin n_fail++; $display("FAIL t3_req: got req=%b addr=%h want 1/100", mem_req, mem_addr); end
    mem_gnt = 1'b1; tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5678_1234; tick();
    mem_rvalid = 1'b0;
    n_checks++; if (inst_valid !== 1'b1 || inst !== 16'h5678 || inst_pc !== 32'h102) begin n_fail++; $display("FAIL t3_hi: got v=%b %h@%h want 1 5678@102", inst_valid, inst, inst_pc); end
    inst_ready = 1'b1; tick();
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL t3_one_half: got v=%b %h@%h want v=0", inst_valid, inst, inst_pc); end
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h104) begin n_fail++; $display("FAIL t3_next: got req=%b addr=%h want 1/104", mem_req, mem_addr); end
    inst_ready = 1'b0;
  endtask

  task automatic test_redirect_same_cycle();
    apply_reset();
    tick();
    mem_gnt = 1'b1; tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h2222_1111; tick();
    mem_rvalid = 1'b0; tick();
    mem_gnt = 1'b1; tick();
    mem_gnt = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    mem_rvalid = 1'b1; mem_rdata = 32'h4444_3333; inst_ready = 1'b1;
    tick();
    redirect = 1'b0; mem_rvalid = 1'b0;
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL t4_flush: got v=%b %h@%h want v=0", inst_valid, inst, inst_pc); end
    tick();
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL t4_no_stale: got v=%b %h@%h want v=0", inst_valid, inst, inst_pc); end
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin n_fail++; $display("FAIL t4_req: got req=%b addr=%h want 1/200", mem_req, mem_addr); end
    mem_gnt = 1'b1; tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0F0F_1E1E; tick();
    mem_rvalid = 1'b0;
    n_checks++; if (inst_valid !== 1'b1 || inst !== 16'h1E1E || inst_pc !== 32'h200) begin n_fail++; $display("FAIL t4_new0: got v=%b %h@%h want 1 1e1e@200", inst_valid, inst, inst_pc); end
    tick();
    n_checks++; if (inst_valid !== 1'b1 || inst !== 16'h0F0F || inst_pc !== 32'h202) begin n_fail++; $display("FAIL t4_new1: got v=%b %h@%h want 1 0f0f@202", inst_valid, inst, inst_pc); end
    inst_ready = 1'b0;
  endtask

  task automatic test_redirect_latency();
    apply_reset();
    redirect = 1'b1; redirect_pc = 32'h0000_0041;
    tick();
    redirect = 1'b0;
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin n_fail++; $display("FAIL t_lat_req: got req=%b addr=%h want 1/40", mem_req, mem_addr); end
    mem_gnt = 1'b1; tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hC002_C001; tick();
    mem_rvalid = 1'b0;
    n_checks++; if (inst_valid !== 1'b1 || inst !== 16'hC001 || inst_pc !== 32'h40) begin n_fail++; $display("FAIL t_lat_valid: got v=%b %h@%h want 1 c001@40", inst_valid, inst, inst_pc); end
  endtask

  task automatic test_redirect_req();
    apply_reset();
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0300; tick();
    redirect = 1'b0;
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL t5_stable0: got req=%b addr=%h want 1/0", mem_req, mem_addr); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL t5_stable[%0d]: got req=%b addr=%h want 1/0", i, mem_req, mem_addr); end
    end
    mem_gnt = 1'b1; tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h9999_8888; tick();
    mem_rvalid = 1'b0;
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL t5_dropped: got v=%b %h@%h want v=0", inst_valid, inst, inst_pc); end
    tick();
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin n_fail++; $display("FAIL t5_refetch: got req=%b addr=%h want 1/300", mem_req, mem_addr); end
    mem_gnt = 1'b1; tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h7777_6666; tick();
    mem_rvalid = 1'b0;
    n_checks++; if (inst_valid !== 1'b1 || inst !== 16'h6666 || inst_pc !== 32'h300) begin n_fail++; $display("FAIL t5_new: got v=%b %h@%h want 1 6666@300", inst_valid, inst, inst_pc); end
  endtask

  task automatic test_wrap_and_async_reset();
    mem_gnt = 1'b0; mem_rvalid = 1'b0; inst_ready = 1'b0; redirect = 1'b0;
    reset_w = 1'b1;
    tick();
    n_checks++; if (w_mem_req !== 1'b1 || w_mem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL t6_req: got req=%b addr=%h want 1/fffffffc", w_mem_req, w_mem_addr); end
    mem_gnt = 1'b1; tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBBBB_AAAA; tick();
    mem_rvalid = 1'b0;
    n_checks++; if (w_inst_valid !== 1'b1 || w_inst !== 16'hAAAA || w_inst_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL t6_lo: got v=%b %h@%h want 1 aaaa@fffffffc", w_inst_valid, w_inst, w_inst_pc); end
    inst_ready = 1'b1; tick();
    n_checks++; if (w_inst !== 16'hBBBB || w_inst_pc !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL t6_hi: got %h@%h want bbbb@fffffffe", w_inst, w_inst_pc); end
    n_checks++; if (w_mem_req !== 1'b1 || w_mem_addr !== 32'h0) begin n_fail++; $display("FAIL t6_wrap: got req=%b addr=%h want 1/0", w_mem_req, w_mem_addr); end
    mem_gnt = 1'b1; tick();
    mem_gnt = 1'b0; inst_ready = 1'b0;
    #2 reset_w = 1'b0;
    #1;
    n_checks++; if (w_mem_req !== 1'b0 || w_mem_addr !== 32'h0 || w_inst_valid !== 1'b0 || w_inst !== 16'h0 || w_inst_pc !== 32'h0) begin n_fail++; $display("FAIL t6_async: got req=%b addr=%h v=%b %h@%h want all 0", w_mem_req, w_mem_addr, w_inst_valid, w_inst, w_inst_pc); end
    tick();
    reset_w = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; tick();
    mem_rvalid = 1'b0;
    n_checks++; if (w_inst_valid !== 1'b0) begin n_fail++; $display("FAIL t6_no_push: got v=%b %h@%h want v=0", w_inst_valid, w_inst, w_inst_pc); end
    n_checks++; if (w_mem_req !== 1'b1 || w_mem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL t6_restart: got req=%b addr=%h want 1/fffffffc", w_mem_req, w_mem_addr); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; reset_w = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    tick(); tick();
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_redirect_latency();
    test_redirect_req();
    test_wrap_and_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
